alu_lockstep_monitor: RTL

//  Synthesizable N-channel lockstep comparator for the Trojan-detection flow.

---
 rtl/alu_trojan_pkg.sv | 25 ++
 rtl/alu_lockstep_chan.sv | 104 ++++++++++
 rtl/alu_lockstep_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_trojan_pkg.sv
// Shared definitions for the ALU Trojan-detection lockstep monitor:
// per-channel classifier state encoding and the compared-word layout.
package alu_trojan_pkg;

    // Classifier state, kept as plain 2-bit constants so the encoding
    // matches what the feature-extraction scripts already decode.
    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_CLEAN   = 2'b00;
    localparam chan_state_t ST_SUSPECT = 2'b01;
    localparam chan_state_t ST_ALARM   = 2'b10;

    // Widest ALU result the packing helper accepts; callers size-cast down.
    localparam int PACK_MAX_W = 32;

    // Compared word layout: {result, carry, zero}.
    function automatic logic [PACK_MAX_W+1:0] pack_word(
        input logic [PACK_MAX_W-1:0] result,
        input logic                  carry,
        input logic                  zero
    );
        return {result, carry, zero};
    endfunction

endpackage

// File: rtl/alu_lockstep_chan.sv
// One lockstep channel: compares the channel word against the golden word,
// keeps a saturating mismatch count and runs the CLEAN/SUSPECT/ALARM
// classifier over a window of valid samples.
module alu_lockstep_chan
    import alu_trojan_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = 16,
    parameter int WIN          = 8,
    parameter int ALARM_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               sample_valid,
    input  logic [WIDTH+1:0]   exp_word,
    input  logic [WIDTH-1:0]   result,
    input  logic               carry,
    input  logic               zero,
    output logic [WIDTH+1:0]   obs_word,
    output logic               mm,
    output logic               mismatch,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output chan_state_t        state
);

    localparam int WW = WIDTH + 2;
    // Room for WIN+1 so the incremented age never wraps before the compare.
    localparam int AW = $clog2(WIN + 2);
    localparam logic [AW-1:0] THRESH_V = AW'(ALARM_THRESH);
    localparam logic [AW-1:0] WIN_V    = AW'(WIN);

    logic [AW-1:0] hits;
    logic [AW-1:0] age;
    logic [AW-1:0] hits_nxt;
    logic [AW-1:0] age_nxt;

    assign obs_word = WW'(pack_word(PACK_MAX_W'(result), carry, zero));

    // Anything other than a definite "equal" (including X/Z inputs) is a mismatch.
    assign mm = ((obs_word == exp_word) !== 1'b1);

    // Window bookkeeping as it would look after the current sample.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hits_nxt = hits + AW'(mm);
        age_nxt  = age + AW'(1);
    end

    // Mismatch flag, saturating count and classifier; only valid samples advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            state        <= ST_CLEAN;
            hits         <= '0;
            age          <= '0;
        end else if (clear) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            state        <= ST_CLEAN;
            hits         <= '0;
            age          <= '0;
        end else if (sample_valid) begin
            mismatch <= mm;
            if (mm && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            case (state)
                ST_CLEAN: begin
                    if (mm) begin
                        hits  <= AW'(1);
                        age   <= AW'(1);
                        state <= (ALARM_THRESH == 1) ? ST_ALARM : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (hits_nxt == THRESH_V) begin
                        hits  <= hits_nxt;
                        age   <= age_nxt;
                        state <= ST_ALARM;
                    end else if (age_nxt >= WIN_V) begin
                        hits  <= '0;
                        age   <= '0;
                        state <= ST_CLEAN;
                    end else begin
                        hits <= hits_nxt;
                        age  <= age_nxt;
                    end
                end
                ST_ALARM: begin
                    state <= ST_ALARM;
                end
                default: begin
                    state <= ST_CLEAN;
                end
            endcase
        end else begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_lockstep_monitor.sv
// N-channel lockstep comparator: golden ALU versus each ALU under test.
// Holds the shared sample counter and the first-divergence capture; the
// per-channel compare/count/classify logic lives in alu_lockstep_chan.
module alu_lockstep_monitor
    import alu_trojan_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int NCH          = 4,
    parameter int CNT_W        = 16,
    parameter int WIN          = 8,
    parameter int ALARM_THRESH = 3,
    parameter int FCW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     ref_result,
    input  logic                 ref_carry,
    input  logic                 ref_zero,
    input  logic [NCH*WIDTH-1:0] dut_result,
    input  logic [NCH-1:0]       dut_carry,
    input  logic [NCH-1:0]       dut_zero,
    output logic [NCH-1:0]       mismatch_vec,
    output logic [NCH*CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [NCH*2-1:0]     state_vec,
    output logic [NCH-1:0]       alarm,
    output logic                 first_valid,
    output logic [FCW-1:0]       first_ch,
    output logic [CNT_W-1:0]     first_sample,
    output logic [WIDTH+1:0]     first_exp,
    output logic [WIDTH+1:0]     first_obs
);

    localparam int WW = WIDTH + 2;

    logic [WW-1:0]  exp_word;
    logic [WW-1:0]  obs_word [NCH];
    logic [NCH-1:0] mm;
    logic [FCW-1:0] hit_ch;
    logic [WW-1:0]  hit_word;

    assign exp_word = WW'(pack_word(PACK_MAX_W'(ref_result), ref_carry, ref_zero));

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        alu_lockstep_chan #(
            .WIDTH        (WIDTH),
            .CNT_W        (CNT_W),
            .WIN          (WIN),
            .ALARM_THRESH (ALARM_THRESH)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (clear),
            .sample_valid (sample_valid),
            .exp_word     (exp_word),
            .result       (dut_result[c*WIDTH +: WIDTH]),
            .carry        (dut_carry[c]),
            .zero         (dut_zero[c]),
            .obs_word     (obs_word[c]),
            .mm           (mm[c]),
            .mismatch     (mismatch_vec[c]),
            .mismatch_cnt (mismatch_cnt[c*CNT_W +: CNT_W]),
            .state        (state_vec[c*2 +: 2])
        );

        assign alarm[c] = (state_vec[c*2 +: 2] == ST_ALARM);
    end

    // Lowest-index mismatching channel and its word; scanning downward lets
    // the lowest index overwrite any higher one.
    always_comb begin
        hit_ch   = '0;
        hit_word = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (mm[c]) begin
                hit_ch   = FCW'(c);
                hit_word = obs_word[c];
            end
        end
    end

    // Sample counter and one-shot first-divergence capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= '0;
            first_valid  <= 1'b0;
            first_ch     <= '0;
            first_sample <= '0;
            first_exp    <= '0;
            first_obs    <= '0;
        end else if (clear) begin
            sample_cnt   <= '0;
            first_valid  <= 1'b0;
            first_ch     <= '0;
            first_sample <= '0;
            first_exp    <= '0;
            first_obs    <= '0;
        end else if (sample_valid) begin
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (!first_valid && (|mm)) begin
                first_valid  <= 1'b1;
                first_ch     <= hit_ch;
                first_sample <= sample_cnt;
                first_exp    <= exp_word;
                first_obs    <= hit_word;
            end
        end
    end

endmodule
